// File: rtl/program_loader_pkg.sv
// Shared state encoding and constants for the program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI_WAIT,
    LEN_LO,
    W_HI,
    W_LO,
    RUN,
    SEND
  } state_t;

  localparam logic [4:0] HALT_OPCODE  = 5'b00000;
  localparam int         REPORT_BYTES = 4;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/program_loader_tx_serializer.sv
// Sends a 32-bit report as 4 UART bytes, MSB first,
// one tx_start per byte and waiting on tx_done in between.
module program_loader_tx_serializer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] report,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] shreg;
  logic [1:0]  idx;
  logic        active;

  assign done = active && tx_done &&
                (idx == 2'(REPORT_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg    <= '0;
      idx      <= '0;
      active   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        idx      <= '0;
        shreg    <= report << 8;
        tx_data  <= report[31:24];
        tx_start <= 1'b1;
      end else if (active && tx_done) begin
        if (done) begin
          active <= 1'b0;
        end else begin
          idx      <= idx + 2'd1;
          tx_data  <= shreg[31:24];
          shreg    <= shreg << 8;
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a UART program image into program memory, runs the cpu
// until HALT is fetched, then reports cycle count and PC over UART.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter int         DATA_W    = 16,
  parameter int         MEM_DEPTH = 2048,
  parameter logic [4:0] HALT_OP   = HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [DATA_W-1:0] cpu_instr,
  output logic              busy
);

  state_t      state, state_nx;
  logic [7:0]  len_hi, w_hi;
  logic [15:0] n_words, idx, cyc;
  logic [31:0] report;
  logic        halt, in_range;
  logic        ser_start, ser_done;
  logic        unused_ok;

  assign halt      = cpu_instr[DATA_W-1 -: 5] == HALT_OP;
  assign unused_ok = ^cpu_instr[DATA_W-6:0];
  assign in_range  = {1'b0, idx} < 17'(MEM_DEPTH);
  assign busy      = state != IDLE;
  assign ser_start = (state == RUN) && halt;
  assign report    = {cyc, 16'(cpu_pc)};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (rx_done) state_nx = LEN_LO;
      LEN_LO: if (rx_done)
                state_nx = ({len_hi, rx_data} == 16'd0) ? RUN : W_HI;
      W_HI:   if (rx_done) state_nx = W_LO;
      W_LO:   if (rx_done)
                state_nx = (idx + 16'd1 == n_words) ? RUN : W_HI;
      RUN:    if (halt) state_nx = SEND;
      SEND:   if (ser_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Out-of-range words still advance idx so framing stays aligned
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi    <= '0;
      w_hi      <= '0;
      n_words   <= '0;
      idx       <= '0;
      cyc       <= '0;
      pm_we     <= 1'b0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      cpu_reset <= 1'b0;
    end else begin
      pm_we     <= 1'b0;
      cpu_reset <= state_nx == RUN;
      if (state == IDLE && rx_done)
        len_hi <= rx_data;
      if (state == LEN_LO && rx_done) begin
        n_words <= {len_hi, rx_data};
        idx     <= '0;
      end
      if (state == W_HI && rx_done)
        w_hi <= rx_data;
      if (state == W_LO && rx_done) begin
        pm_we    <= in_range;
        pm_addr  <= idx[ADDR_W-1:0];
        pm_wdata <= DATA_W'({w_hi, rx_data});
        idx      <= idx + 16'd1;
      end
      if (state != RUN) cyc <= '0;
      else if (!halt)   cyc <= sat_inc(cyc);
    end
  end

  program_loader_tx_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .report   (report),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with memory, cpu and uart tx models.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        pm_we;
  logic [10:0] pm_addr;
  logic [15:0] pm_wdata;
  logic        cpu_reset;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_instr;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mem [0:2047];
  logic [10:0] pc;
  int          mode;
  int          we_cnt = 0;
  int          we0;
  int          n_start = 0;
  int          n_push = 0;
  logic [7:0]  tx_q [$];
  logic [10:0] exp_pc;
  logic [15:0] w;

  always #5 clk = ~clk;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .pm_we     (pm_we),
    .pm_addr   (pm_addr),
    .pm_wdata  (pm_wdata),
    .cpu_reset (cpu_reset),
    .cpu_pc    (cpu_pc),
    .cpu_instr (cpu_instr),
    .busy      (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (pm_we) begin
      mem[pm_addr] <= pm_wdata;
      we_cnt       <= we_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!cpu_reset) pc <= '0;
    else            pc <= pc + 11'd1;
  end
  assign cpu_pc = pc;

  // mode 1: never halt, mode 2: always halt, else fetch from memory
  always_comb begin
    cpu_instr = mem[pc];
    if (mode == 1) cpu_instr = 16'h0800;
    if (mode == 2) cpu_instr = 16'h0000;
  end

  always @(negedge clk)
    if (tx_start) n_start <= n_start + 1;

  initial begin
    tx_done = 1'b0;
    forever begin
      if (tx_start) begin
        tx_q.push_back(tx_data);
        n_push++;
        repeat (3) @(negedge clk);
        chk("tx_one_start", n_start, n_push);
        chk("tx_data_hold", 32'(tx_data), 32'(tx_q[$]));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_last(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic collect(
    input string       tag,
    input logic [31:0] exp,
    input bit          poke
  );
    int i = 0;
    while (!(tx_q.size() >= 4 && !busy) && i < 400) begin
      rx_done = poke & i[0];
      rx_data = 8'hAA;
      @(negedge clk);
      i++;
    end
    rx_done = 1'b0;
    chk({tag, "_done"}, (tx_q.size() == 4 && !busy) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++)
      chk(tag, (k < tx_q.size()) ? 32'(tx_q[k]) : 32'hDEAD,
          32'(exp[31-8*k -: 8]));
    tx_q.delete();
  endtask

  initial begin
    reset   = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    mode    = 0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 0);
    chk("rst_pm_we", 32'(pm_we), 0);
    chk("rst_pm_addr", 32'(pm_addr), 0);
    chk("rst_pm_wdata", 32'(pm_wdata), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clk);

    we0 = we_cnt;
    send(8'h00); send(8'h03);
    send(8'h10); send(8'h01);
    send(8'h20); send(8'h02);
    send(8'h00);
    chk("load_busy", 32'(busy), 1);
    chk("load_cpu_held", 32'(cpu_reset), 0);
    send_last(8'h00);
    chk("load_cpu_rel", 32'(cpu_reset), 1);
    chk("load_we", 32'(pm_we), 1);
    chk("load_addr", 32'(pm_addr), 2);
    chk("load_wdata", 32'(pm_wdata), 32'h0000);
    collect("run_rep", 32'h0002_0002, 1'b1);
    chk("run_we_cnt", we_cnt - we0, 3);
    chk("run_mem0", 32'(mem[0]), 32'h1001);
    chk("run_mem1", 32'(mem[1]), 32'h2002);
    chk("run_mem2", 32'(mem[2]), 32'h0000);
    chk("run_cpu_off", 32'(cpu_reset), 0);

    we0  = we_cnt;
    mode = 2;
    send(8'h00);
    send_last(8'h00);
    chk("n0_cpu_rel", 32'(cpu_reset), 1);
    chk("n0_we", 32'(pm_we), 0);
    collect("n0_rep", 32'h0000_0000, 1'b0);
    chk("n0_we_cnt", we_cnt - we0, 0);
    mode = 0;

    send(8'h00); send(8'h02);
    send(8'hAB); send(8'hCD); send(8'h12);
    chk("mid_pre_wdata", 32'(pm_wdata), 32'hABCD);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_we", 32'(pm_we), 0);
    chk("mid_addr", 32'(pm_addr), 0);
    chk("mid_wdata", 32'(pm_wdata), 0);
    chk("mid_cpu", 32'(cpu_reset), 0);
    reset = 1'b1;
    @(negedge clk);
    send(8'h00); send(8'h01); send(8'h55);
    send_last(8'h66);
    chk("fresh_we", 32'(pm_we), 1);
    chk("fresh_addr", 32'(pm_addr), 0);
    chk("fresh_wdata", 32'(pm_wdata), 32'h5566);
    chk("fresh_cpu", 32'(cpu_reset), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    mode = 1;
    we0  = we_cnt;
    send(8'h08); send(8'h02);
    for (int i = 0; i < 2049; i++) begin
      w = 16'h8000 | 16'(i);
      send(w[15:8]);
      send(w[7:0]);
    end
    send(8'h88);
    send_last(8'h01);
    chk("sat_cpu_rel", 32'(cpu_reset), 1);
    chk("sat_we_last", 32'(pm_we), 0);
    @(negedge clk);
    chk("sat_we_cnt", we_cnt - we0, 2048);
    chk("sat_mem0", 32'(mem[0]), 32'h8000);
    chk("sat_mem_top", 32'(mem[2047]), 32'h87FF);
    repeat (70000) @(negedge clk);
    chk("sat_busy", 32'(busy), 1);
    exp_pc = pc;
    mode   = 2;
    collect("sat_rep", {16'hFFFF, 5'b0, exp_pc}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
